// File: rtl/alu_seq.sv
// Accumulator ALU with acc, result latch and C/Z flags. Most ops finish on the accept edge.
// Shifts run one bit per cycle and multiply runs one shift-add step per cycle.
module alu_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SHW    = $clog2(WIDTH) + 1,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             tclk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] d_in,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] latch,
    output logic             c,
    output logic             z,
    output logic             busy,
    output logic             done
);
    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpNand = 4'd2;
    localparam logic [3:0] OpShr  = 4'd3;
    localparam logic [3:0] OpShl  = 4'd4;
    localparam logic [3:0] OpLd   = 4'd5;
    localparam logic [3:0] OpSt   = 4'd6;
    localparam logic [3:0] OpAdc  = 4'd7;
    localparam logic [3:0] OpSbc  = 4'd8;
    localparam logic [3:0] OpMul  = 4'd9;
    localparam logic [3:0] OpMva  = 4'd10;

    typedef enum logic [1:0] {StIdle, StShift, StMul} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d, latch_q, latch_d;
    logic [WIDTH-1:0]     work_q, work_d, mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d, prod_q, prod_d;
    logic [SHW-1:0]       cnt_q, cnt_d, k;
    logic                 c_q, c_d, z_q, z_d, busy_q, busy_d, done_q, done_d, left_q, left_d;
    logic [WIDTH:0]       sum, diff;
    logic [WIDTH-1:0]     res;
    logic                 res_c, wr_res;

    always_ff @(posedge tclk) begin
        if (!reset) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            latch_q  <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            left_q   <= 1'b0;
            work_q   <= '0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            latch_q  <= latch_d;
            c_q      <= c_d;
            z_q      <= z_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            left_q   <= left_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        latch_d  = latch_q;
        c_d      = c_q;
        z_d      = z_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        left_d   = left_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        res      = '0;
        res_c    = 1'b0;
        wr_res   = 1'b0;
        k        = (shamt > SHW'(WIDTH)) ? SHW'(WIDTH) : shamt;
        sum      = {1'b0, acc_q} + {1'b0, d_in} + {{WIDTH{1'b0}}, (op == OpAdc) & c_q};
        // Bit WIDTH of the difference is the borrow out.
        diff     = {1'b0, acc_q} - {1'b0, d_in} - {{WIDTH{1'b0}}, (op == OpSbc) & c_q};

        unique case (state_q)
            StIdle: begin
                if (op_valid) begin
                    done_d = 1'b1;
                    case (op)
                        OpAdd, OpAdc: begin
                            res = sum[WIDTH-1:0]; res_c = sum[WIDTH]; wr_res = 1'b1;
                        end
                        OpSub, OpSbc: begin
                            res = diff[WIDTH-1:0]; res_c = diff[WIDTH]; wr_res = 1'b1;
                        end
                        OpNand: begin
                            res = ~(acc_q & d_in); wr_res = 1'b1;
                        end
                        OpShr, OpShl: begin
                            if (k == '0) begin
                                res = acc_q; wr_res = 1'b1;
                            end else begin
                                work_d  = acc_q;
                                cnt_d   = k;
                                left_d  = (op == OpShl);
                                busy_d  = 1'b1;
                                done_d  = 1'b0;
                                state_d = StShift;
                            end
                        end
                        OpLd:  acc_d   = d_in;
                        OpSt:  latch_d = acc_q;
                        OpMul: begin
                            if (MUL_EN) begin
                                mcand_d  = {{WIDTH{1'b0}}, acc_q};
                                mplier_d = d_in;
                                prod_d   = '0;
                                cnt_d    = SHW'(WIDTH);
                                busy_d   = 1'b1;
                                done_d   = 1'b0;
                                state_d  = StMul;
                            end
                        end
                        OpMva: acc_d = latch_q;
                        default: ;
                    endcase
                end
            end
            StShift: begin
                res_c  = left_q ? work_q[WIDTH-1] : work_q[0];
                work_d = left_q ? (work_q << 1) : (work_q >> 1);
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    res = work_d; wr_res = 1'b1;
                    busy_d = 1'b0; done_d = 1'b1; state_d = StIdle;
                end
            end
            StMul: begin
                prod_d   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    res = prod_d[WIDTH-1:0]; res_c = |prod_d[2*WIDTH-1:WIDTH]; wr_res = 1'b1;
                    busy_d = 1'b0; done_d = 1'b1; state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (wr_res) begin
            latch_d = res;
            c_d     = res_c;
            z_d     = (res == '0);
        end
    end

    always_comb begin
        acc   = acc_q;
        latch = latch_q;
        c     = c_q;
        z     = z_q;
        busy  = busy_q;
        done  = done_q;
    end
endmodule

// File: tb/tb_alu_seq.sv
// Randomised scoreboard bench for alu_seq (WIDTH=8): a driver predicts each accepted op's
// outcome and done cycle, while a monitor checks every cycle against the queued predictions.
module tb_alu_seq;
    logic       tclk, reset, op_valid;
    logic [3:0] op;
    logic [7:0] d_in;
    logic [3:0] shamt;
    logic [7:0] acc, latch;
    logic       c, z, busy, done;

    alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .tclk(tclk), .reset(reset), .op_valid(op_valid), .op(op), .d_in(d_in), .shamt(shamt),
        .acc(acc), .latch(latch), .c(c), .z(z), .busy(busy), .done(done)
    );

    typedef struct {
        int         cyc;
        logic [7:0] acc;
        logic [7:0] latch;
        logic       c;
        logic       z;
    } exp_t;

    exp_t sbq[$];
    exp_t vis;
    int   cyc = 0;
    int   last_done = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_acc = 0, m_latch = 0, m_c = 0, m_z = 0;

    initial tclk = 1'b0;
    always #5 tclk = ~tclk;
    always @(posedge tclk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: architectural effect of one accepted op, plus its latency in cycles.
    task automatic predict(input int o, input int d, input int sh, output int lat);
        int a = m_acc, r = 0, cc = 0, s, kk;
        bit wr = 1'b1;
        lat = 0;
        kk = (sh > 8) ? 8 : sh;
        case (o)
            0, 7: begin
                s = a + d + ((o == 7) ? m_c : 0);
                r = s % 256; cc = (s >= 256) ? 1 : 0;
            end
            1, 8: begin
                s = d + ((o == 8) ? m_c : 0);
                r = (a - s) & 255; cc = (a < s) ? 1 : 0;
            end
            2: r = ~(a & d) & 255;
            3: begin
                if (kk == 0) r = a;
                else begin cc = (a >> (kk - 1)) & 1; r = a >> kk; lat = kk; end
            end
            4: begin
                if (kk == 0) r = a;
                else begin cc = ((a << (kk - 1)) >> 7) & 1; r = (a << kk) & 255; lat = kk; end
            end
            9: begin
                s = a * d; r = s & 255; cc = ((s >> 8) != 0) ? 1 : 0; lat = 8;
            end
            default: wr = 1'b0;
        endcase
        if (wr) begin m_latch = r; m_c = cc; m_z = (r == 0) ? 1 : 0; end
        if (o == 5) m_acc = d;
        if (o == 6) m_latch = m_acc;
        if (o == 10) m_acc = m_latch;
    endtask

    // Drive inputs for the coming edge; the model decides whether the DUT can accept.
    task automatic drive(input bit v, input int o, input int d, input int sh);
        int   lat;
        exp_t e;
        op_valid = v; op = 4'(o); d_in = 8'(d); shamt = 4'(sh);
        if (v && cyc >= last_done) begin
            predict(o, d, sh, lat);
            e.cyc = cyc + 1 + lat;
            e.acc = 8'(m_acc); e.latch = 8'(m_latch); e.c = m_c[0]; e.z = m_z[0];
            sbq.push_back(e);
            last_done = e.cyc;
        end
    endtask

    task automatic step(input bit v, input int o, input int d, input int sh);
        @(negedge tclk);
        drive(v, o, d, sh);
    endtask

    task automatic issue(input int o, input int d, input int sh);
        int guard = 0;
        @(negedge tclk);
        while (cyc < last_done && guard < 40) begin
            op_valid = 1'b0;
            @(negedge tclk);
            guard++;
        end
        if (guard >= 40) chk("idle_timeout", guard, 0);
        drive(1'b1, o, d, sh);
    endtask

    task automatic do_reset();
        @(negedge tclk);
        reset = 1'b0; op_valid = 1'b0;
        sbq.delete();
        m_acc = 0; m_latch = 0; m_c = 0; m_z = 0;
        vis = '{0, 8'h00, 8'h00, 1'b0, 1'b0};
        @(negedge tclk);
        chk("rst_acc", acc, 0);
        chk("rst_latch", latch, 0);
        chk("rst_c", c, 0);
        chk("rst_z", z, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;
        last_done = cyc;
    endtask

    // Monitor: pops a prediction on each done pulse, otherwise checks outputs are held.
    always begin
        exp_t e;
        @(posedge tclk);
        #1;
        if (done) begin
            if (sbq.size() == 0) begin
                chk("spurious_done", done, 0);
            end else begin
                e = sbq.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("acc", acc, e.acc);
                chk("latch", latch, e.latch);
                chk("c", c, e.c);
                chk("z", z, e.z);
                chk("busy_at_done", busy, 0);
                vis = e;
            end
        end else begin
            if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                chk("done_missing", done, 1);
                vis = sbq.pop_front();
            end
            chk("hold_acc", acc, vis.acc);
            chk("hold_latch", latch, vis.latch);
            chk("hold_c", c, vis.c);
            chk("hold_z", z, vis.z);
            chk("busy", busy, (sbq.size() > 0) ? 1 : 0);
        end
    end

    localparam int NDIR = 20;
    int dir_op[NDIR] = '{5, 0, 7, 5, 1, 5, 1, 8, 5, 4, 3, 4, 5, 9, 5, 9, 0, 6, 10, 12};
    int dir_d[NDIR]  = '{'hF0, 'h20, 'h00, 'h05, 'h05, 'h03, 'h05, 'h00, 'h81, 0, 0, 0,
                         'h10, 'h20, 'h0F, 'h0F, 'h22, 0, 0, 'h5A};
    int dir_sh[NDIR] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 15, 0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        int o;
        reset = 1'b0; op_valid = 1'b0; op = '0; d_in = '0; shamt = '0;
        vis = '{0, 8'h00, 8'h00, 1'b0, 1'b0};
        repeat (2) @(negedge tclk);
        do_reset();

        for (int i = 0; i < NDIR; i++) issue(dir_op[i], dir_d[i], dir_sh[i]);

        // Back-to-back random traffic; requests landing while busy must be dropped.
        for (int i = 0; i < 500; i++) begin
            o = ($urandom_range(0, 4) == 0) ? 5 : $urandom_range(0, 15);
            step(($urandom_range(0, 3) != 0), o, $urandom_range(0, 255), $urandom_range(0, 15));
        end

        // Ignored request during a multiply, then reset mid-multiply.
        issue(5, 'h10, 0);
        issue(9, 'h20, 0);
        step(1'b0, 0, 0, 0);
        step(1'b1, 0, 'h55, 0);
        step(1'b0, 0, 0, 0);
        do_reset();
        issue(5, 'h33, 0);
        issue(0, 'h11, 0);
        issue(9, 'h07, 0);
        issue(6, 0, 0);

        for (int i = 0; i < 30 && sbq.size() > 0; i++) step(1'b0, 0, 0, 0);
        step(1'b0, 0, 0, 0);
        chk("drain", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
